// File: rtl/sisobidi_seq_ctrl.sv
// Frame sequencer for the 4-bit bidirectional SISO register: serialises a latched word
// LSB first and captures the returning bits. Optional loopback compare: SISOSEQ_LOOPCHK_EN.
module sisobidi_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int LAT   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] tx_word,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_word,
    output logic             sd_dir,
    output logic             sd_data,
    input  logic             sd_serial_in
`ifdef SISOSEQ_LOOPCHK_EN
    ,
    output logic             mismatch
`endif
);

    localparam int CW = $clog2(WIDTH + LAT + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH + LAT - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d, k;
    logic [WIDTH-1:0] tx_q, tx_d, rx_d;
    logic             busy_d, done_d, sd_dir_d, sd_data_d;
`ifdef SISOSEQ_LOOPCHK_EN
    logic             mismatch_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_word;
        busy_d    = busy;
        done_d    = 1'b0;
        sd_dir_d  = sd_dir;
        sd_data_d = 1'b0;
        k         = cnt_q + CW'(1);
`ifdef SISOSEQ_LOOPCHK_EN
        mismatch_d = mismatch;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    tx_d      = tx_word;
                    busy_d    = 1'b1;
                    sd_dir_d  = dir;
                    sd_data_d = tx_word[0];
`ifdef SISOSEQ_LOOPCHK_EN
                    mismatch_d = 1'b0;
`endif
                end
            end
            RUN: begin
                cnt_d = k;
                // Edge E_k drives bit k; past the word the line is zero-filled.
                for (int i = 1; i < WIDTH; i++)
                    if (k == CW'(i)) sd_data_d = tx_q[i];
                // Bit i returns LAT edges after it was driven, sampled on the next edge.
                for (int i = 0; i < WIDTH; i++)
                    if (cnt_q == CW'(i + LAT)) rx_d[i] = sd_serial_in;
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`ifdef SISOSEQ_LOOPCHK_EN
                    mismatch_d = (rx_d != tx_q);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tx_q     <= '0;
            rx_word  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sd_dir   <= 1'b0;
            sd_data  <= 1'b0;
`ifdef SISOSEQ_LOOPCHK_EN
            mismatch <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tx_q     <= tx_d;
            rx_word  <= rx_d;
            busy     <= busy_d;
            done     <= done_d;
            sd_dir   <= sd_dir_d;
            sd_data  <= sd_data_d;
`ifdef SISOSEQ_LOOPCHK_EN
            mismatch <= mismatch_d;
`endif
        end
    end

endmodule
